// File: rtl/regfile_wr_arb_pkg.sv
// Shared defaults and requester indices for the register-file write arbiter
// and the core that instantiates it.
package regfile_wr_arb_pkg;

    localparam int unsigned WORD_LEN_DEF      = 16;
    localparam int unsigned REG_ADDR_LEN_DEF  = 3;
    localparam int unsigned REG_FILE_SIZE_DEF = 8;
    localparam int unsigned N_REQ             = 2;

    localparam logic REQ_CORE = 1'b0;
    localparam logic REQ_DBG  = 1'b1;

endpackage

// File: rtl/regfile_wr_arb_wr_slot.sv
// One-entry write buffer for a single requester; a load on the draining edge
// refills the slot.
module wr_slot
    import regfile_wr_arb_pkg::*;
#(
    parameter int unsigned p_WORD_LEN     = WORD_LEN_DEF,
    parameter int unsigned p_REG_ADDR_LEN = REG_ADDR_LEN_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load,
    input  logic                      drain,
    input  logic [p_REG_ADDR_LEN-1:0] load_tgt,
    input  logic [p_WORD_LEN-1:0]     load_data,
    output logic                      valid,
    output logic [p_REG_ADDR_LEN-1:0] tgt,
    output logic [p_WORD_LEN-1:0]     data
);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            tgt   <= '0;
            data  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            tgt   <= load_tgt;
            data  <= load_data;
        end else if (drain) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/regfile_wr_arb.sv
// Two-requester write arbiter in front of the register file: buffers one write
// per requester, keeps per-register order, round-robins between registers.
module regfile_wr_arb
    import regfile_wr_arb_pkg::*;
#(
    parameter int unsigned p_WORD_LEN      = WORD_LEN_DEF,
    parameter int unsigned p_REG_ADDR_LEN  = REG_ADDR_LEN_DEF,
    parameter int unsigned p_REG_FILE_SIZE = REG_FILE_SIZE_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req0_valid,
    output logic                       req0_ready,
    input  logic [p_REG_ADDR_LEN-1:0]  req0_tgt,
    input  logic [p_WORD_LEN-1:0]      req0_data,
    input  logic                       req1_valid,
    output logic                       req1_ready,
    input  logic [p_REG_ADDR_LEN-1:0]  req1_tgt,
    input  logic [p_WORD_LEN-1:0]      req1_data,
    output logic                       wr_en,
    output logic [p_REG_ADDR_LEN-1:0]  wr_tgt,
    output logic [p_WORD_LEN-1:0]      wr_data,
    output logic [p_REG_FILE_SIZE-1:0] pend_mask,
    output logic                       busy
);

    logic [N_REQ-1:0]          req_valid;
    logic [p_REG_ADDR_LEN-1:0] req_tgt   [N_REQ];
    logic [p_WORD_LEN-1:0]     req_data  [N_REQ];
    logic [N_REQ-1:0]          slot_v;
    logic [p_REG_ADDR_LEN-1:0] slot_tgt  [N_REQ];
    logic [p_WORD_LEN-1:0]     slot_data [N_REQ];
    logic [N_REQ-1:0]          ready;
    logic [N_REQ-1:0]          load;
    logic [N_REQ-1:0]          drain;
    logic [N_REQ-1:0]          keep;
    logic                      gnt_valid;
    logic                      gnt_idx;
    logic                      age_q, age_d;   // index of the older entry
    logic                      last_q, last_d; // index of the last granted requester

    assign req_valid   = {req1_valid, req0_valid};
    assign req_tgt[0]  = req0_tgt;
    assign req_tgt[1]  = req1_tgt;
    assign req_data[0] = req0_data;
    assign req_data[1] = req1_data;

    for (genvar i = 0; i < N_REQ; i++) begin : g_slot
        wr_slot #(
            .p_WORD_LEN     (p_WORD_LEN),
            .p_REG_ADDR_LEN (p_REG_ADDR_LEN)
        ) u_slot (
            .clk       (clk),
            .rst       (rst),
            .load      (load[i]),
            .drain     (drain[i]),
            .load_tgt  (req_tgt[i]),
            .load_data (req_data[i]),
            .valid     (slot_v[i]),
            .tgt       (slot_tgt[i]),
            .data      (slot_data[i])
        );
    end

    // Grant: same register -> older first; different registers -> round-robin.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = REQ_CORE;
        if (!rst) begin
            unique case (slot_v)
                2'b01: begin
                    gnt_valid = 1'b1;
                    gnt_idx   = REQ_CORE;
                end
                2'b10: begin
                    gnt_valid = 1'b1;
                    gnt_idx   = REQ_DBG;
                end
                2'b11: begin
                    gnt_valid = 1'b1;
                    gnt_idx   = (slot_tgt[0] == slot_tgt[1]) ? age_q : ~last_q;
                end
                default: ;
            endcase
        end
    end

    // Handshake, buffer load (r0 writes are swallowed) and age tracking.
    always_comb begin
        drain  = '0;
        load   = '0;
        age_d  = age_q;
        last_d = last_q;
        if (gnt_valid) begin
            drain[gnt_idx] = 1'b1;
            last_d         = gnt_idx;
        end
        ready = ~slot_v | drain;
        keep  = slot_v & ~drain;
        for (int i = 0; i < N_REQ; i++) begin
            load[i] = !rst && req_valid[i] && ready[i] && (req_tgt[i] != '0);
        end
        if (keep[0] && load[1]) begin
            age_d = REQ_CORE;
        end else if (keep[1] && load[0]) begin
            age_d = REQ_DBG;
        end else if (load[0] && load[1]) begin
            age_d = REQ_CORE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            age_q  <= REQ_DBG;
            last_q <= REQ_DBG;
        end else begin
            age_q  <= age_d;
            last_q <= last_d;
        end
    end

    always_comb begin
        pend_mask = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (slot_v[i]) begin
                pend_mask = pend_mask | (p_REG_FILE_SIZE'(1) << slot_tgt[i]);
            end
        end
        pend_mask[0] = 1'b0;
    end

    assign req0_ready = ready[REQ_CORE];
    assign req1_ready = ready[REQ_DBG];
    assign wr_en      = gnt_valid;
    assign wr_tgt     = gnt_valid ? slot_tgt[gnt_idx]  : '0;
    assign wr_data    = gnt_valid ? slot_data[gnt_idx] : '0;
    assign busy       = |slot_v;

endmodule

// File: tb/tb_regfile_wr_arb.sv
// Bench for regfile_wr_arb: directed vector table, back-to-back stream, and
// randomized traffic against an order-stamped reference model.
module tb_regfile_wr_arb;

    localparam int unsigned W = 16;
    localparam int unsigned A = 3;
    localparam int unsigned P = 8;

    logic         clk;
    logic         rst;
    logic         req0_valid, req1_valid;
    logic         req0_ready, req1_ready;
    logic [A-1:0] req0_tgt, req1_tgt;
    logic [W-1:0] req0_data, req1_data;
    logic         wr_en;
    logic [A-1:0] wr_tgt;
    logic [W-1:0] wr_data;
    logic [P-1:0] pend_mask;
    logic         busy;

    regfile_wr_arb #(
        .p_WORD_LEN      (W),
        .p_REG_ADDR_LEN  (A),
        .p_REG_FILE_SIZE (P)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_tgt   (req0_tgt),
        .req0_data  (req0_data),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_tgt   (req1_tgt),
        .req1_data  (req1_data),
        .wr_en      (wr_en),
        .wr_tgt     (wr_tgt),
        .wr_data    (wr_data),
        .pend_mask  (pend_mask),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int step_n = 0;

    typedef struct {
        logic         rst;
        logic         v0;
        logic [A-1:0] t0;
        logic [W-1:0] d0;
        logic         v1;
        logic [A-1:0] t1;
        logic [W-1:0] d1;
        logic         chk;
        logic         en;
        logic [A-1:0] tgt;
        logic [W-1:0] data;
        logic         r0;
        logic         r1;
        logic [P-1:0] pend;
        logic         busy;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(int r, int v0, int t0, int d0, int v1, int t1, int d1,
                                int c, int en, int tgt, int data, int r0, int r1,
                                int pend, int bsy);
        vec_t v;
        v.rst  = 1'(r);
        v.v0   = 1'(v0);
        v.t0   = 3'(t0);
        v.d0   = 16'(d0);
        v.v1   = 1'(v1);
        v.t1   = 3'(t1);
        v.d1   = 16'(d1);
        v.chk  = 1'(c);
        v.en   = 1'(en);
        v.tgt  = 3'(tgt);
        v.data = 16'(data);
        v.r0   = 1'(r0);
        v.r1   = 1'(r1);
        v.pend = 8'(pend);
        v.busy = 1'(bsy);
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got 0x%0h, expected 0x%0h", name, step_n, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic v0, input logic [A-1:0] t0,
                         input logic [W-1:0] d0, input logic v1, input logic [A-1:0] t1,
                         input logic [W-1:0] d1);
        @(negedge clk);
        rst        = r;
        req0_valid = v0;
        req0_tgt   = t0;
        req0_data  = d0;
        req1_valid = v1;
        req1_tgt   = t1;
        req1_data  = d1;
        step_n++;
        #1;
    endtask

    task automatic check_outs(input string tag, input logic en, input logic [A-1:0] tgt,
                              input logic [W-1:0] data, input logic r0, input logic r1,
                              input logic [P-1:0] pend, input logic bsy);
        chk({tag, ".wr_en"},      32'(wr_en),      32'(en));
        chk({tag, ".wr_tgt"},     32'(wr_tgt),     32'(tgt));
        chk({tag, ".wr_data"},    32'(wr_data),    32'(data));
        chk({tag, ".req0_ready"}, 32'(req0_ready), 32'(r0));
        chk({tag, ".req1_ready"}, 32'(req1_ready), 32'(r1));
        chk({tag, ".pend_mask"},  32'(pend_mask),  32'(pend));
        chk({tag, ".busy"},       32'(busy),       32'(bsy));
    endtask

    // Reference model: each buffered write carries an acceptance stamp
    // (cycle*2 + requester), so "older" is simply the smaller stamp.
    bit           mv[2];
    logic [A-1:0] mt[2];
    logic [W-1:0] md[2];
    int           ms[2];
    int           mlast;
    bit           pv[2];
    logic [A-1:0] pt[2];
    logic [W-1:0] pd[2];

    initial begin
        int           g;
        logic         r;
        logic [P-1:0] e_pend;
        bit           e_rdy[2];

        rst = 1'b1;
        req0_valid = 1'b0; req0_tgt = '0; req0_data = '0;
        req1_valid = 1'b0; req1_tgt = '0; req1_data = '0;

        // rst v0 t0 d0  v1 t1 d1  chk | en tgt data  r0 r1 pend busy
        vecs.push_back(mk(1, 0,0,0,       0,0,0,       0, 0,0,0,       0,0, 'h00,0));
        vecs.push_back(mk(0, 0,0,0,       0,0,0,       1, 0,0,0,       1,1, 'h00,0));
        vecs.push_back(mk(0, 1,3,'h1234,  0,0,0,       1, 0,0,0,       1,1, 'h00,0));
        vecs.push_back(mk(0, 0,0,0,       0,0,0,       1, 1,3,'h1234,  1,1, 'h08,1));
        vecs.push_back(mk(0, 0,0,0,       0,0,0,       1, 0,0,0,       1,1, 'h00,0));
        vecs.push_back(mk(0, 0,0,0,       1,0,'hFFFF,  1, 0,0,0,       1,1, 'h00,0));
        vecs.push_back(mk(0, 0,0,0,       0,0,0,       1, 0,0,0,       1,1, 'h00,0));
        vecs.push_back(mk(1, 0,0,0,       0,0,0,       1, 0,0,0,       1,1, 'h00,0));
        vecs.push_back(mk(0, 1,2,'h0202,  1,5,'h0505,  1, 0,0,0,       1,1, 'h00,0));
        vecs.push_back(mk(0, 1,1,'h0101,  1,6,'h0606,  1, 1,2,'h0202,  1,0, 'h24,1));
        vecs.push_back(mk(0, 1,3,'h0303,  1,6,'h0606,  1, 1,5,'h0505,  0,1, 'h22,1));
        vecs.push_back(mk(0, 1,3,'h0303,  1,7,'h0707,  1, 1,1,'h0101,  1,0, 'h42,1));
        vecs.push_back(mk(0, 0,0,0,       1,7,'h0707,  1, 1,6,'h0606,  0,1, 'h48,1));
        vecs.push_back(mk(0, 0,0,0,       0,0,0,       1, 1,3,'h0303,  1,0, 'h88,1));
        vecs.push_back(mk(0, 0,0,0,       0,0,0,       1, 1,7,'h0707,  1,1, 'h80,1));
        vecs.push_back(mk(0, 0,0,0,       0,0,0,       1, 0,0,0,       1,1, 'h00,0));
        vecs.push_back(mk(1, 0,0,0,       0,0,0,       1, 0,0,0,       1,1, 'h00,0));
        vecs.push_back(mk(0, 1,6,'h0606,  1,7,'h0707,  1, 0,0,0,       1,1, 'h00,0));
        vecs.push_back(mk(0, 1,1,'h0101,  0,0,0,       1, 1,6,'h0606,  1,0, 'hC0,1));
        vecs.push_back(mk(0, 1,4,'h5555,  1,4,'hAAAA,  1, 1,7,'h0707,  0,1, 'h82,1));
        vecs.push_back(mk(0, 1,4,'h5555,  0,0,0,       1, 1,1,'h0101,  1,0, 'h12,1));
        vecs.push_back(mk(0, 0,0,0,       0,0,0,       1, 1,4,'hAAAA,  0,1, 'h10,1));
        vecs.push_back(mk(0, 0,0,0,       0,0,0,       1, 1,4,'h5555,  1,1, 'h10,1));
        vecs.push_back(mk(0, 1,5,'h0A0A,  1,5,'h0B0B,  1, 0,0,0,       1,1, 'h00,0));
        vecs.push_back(mk(0, 0,0,0,       0,0,0,       1, 1,5,'h0A0A,  1,0, 'h20,1));
        vecs.push_back(mk(0, 0,0,0,       0,0,0,       1, 1,5,'h0B0B,  1,1, 'h20,1));
        vecs.push_back(mk(0, 0,0,0,       0,0,0,       1, 0,0,0,       1,1, 'h00,0));
        vecs.push_back(mk(0, 1,2,'h2222,  1,3,'h3333,  1, 0,0,0,       1,1, 'h00,0));
        vecs.push_back(mk(1, 1,6,'h6666,  1,7,'h7777,  1, 0,0,0,       0,0, 'h0C,1));
        vecs.push_back(mk(0, 0,0,0,       0,0,0,       1, 0,0,0,       1,1, 'h00,0));
        vecs.push_back(mk(0, 0,0,0,       0,0,0,       1, 0,0,0,       1,1, 'h00,0));

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].v0, vecs[i].t0, vecs[i].d0,
                  vecs[i].v1, vecs[i].t1, vecs[i].d1);
            if (vecs[i].chk) begin
                check_outs($sformatf("vec%0d", i), vecs[i].en, vecs[i].tgt, vecs[i].data,
                           vecs[i].r0, vecs[i].r1, vecs[i].pend, vecs[i].busy);
            end
        end

        // Back-to-back stream on requester 0: one write per cycle, in order.
        drive(1'b1, 1'b0, '0, '0, 1'b0, '0, '0);
        for (int i = 1; i <= 8; i++) begin
            if (i <= 7) begin
                drive(1'b0, 1'b1, 3'(i), 16'(i * 'h1111), 1'b0, '0, '0);
            end else begin
                drive(1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
            end
            chk("b2b.req0_ready", 32'(req0_ready), 32'd1);
            if (i == 1) begin
                chk("b2b.wr_en", 32'(wr_en), 32'd0);
            end else begin
                chk("b2b.wr_en",   32'(wr_en),   32'd1);
                chk("b2b.wr_tgt",  32'(wr_tgt),  32'(i - 1));
                chk("b2b.wr_data", 32'(wr_data), 32'((i - 1) * 'h1111));
            end
        end

        // Randomized traffic; a request is held until accepted.
        for (int k = 0; k < 2; k++) begin
            mv[k] = 1'b0; pv[k] = 1'b0; mt[k] = '0; md[k] = '0; ms[k] = 0;
            pt[k] = '0; pd[k] = '0;
        end
        mlast = 1;
        for (int c = 0; c < 3000; c++) begin
            r = (c == 0) || ($urandom_range(0, 99) == 0);
            for (int k = 0; k < 2; k++) begin
                if (!pv[k] && $urandom_range(0, 3) != 0) begin
                    pv[k] = 1'b1;
                    pt[k] = ($urandom_range(0, 1) == 1) ? 3'($urandom_range(0, 2))
                                                        : 3'($urandom_range(0, 7));
                    pd[k] = 16'($urandom);
                end
            end
            drive(r, pv[0], pt[0], pd[0], pv[1], pt[1], pd[1]);

            g = -1;
            if (!r) begin
                if (mv[0] && mv[1]) begin
                    if (mt[0] == mt[1]) g = (ms[0] < ms[1]) ? 0 : 1;
                    else                g = (mlast == 0) ? 1 : 0;
                end else if (mv[0]) begin
                    g = 0;
                end else if (mv[1]) begin
                    g = 1;
                end
            end
            e_pend = '0;
            for (int k = 0; k < 2; k++) begin
                e_rdy[k] = !mv[k] || (g == k);
                if (mv[k]) e_pend[mt[k]] = 1'b1;
            end
            check_outs("rnd", g >= 0, (g >= 0) ? mt[g] : 3'd0, (g >= 0) ? md[g] : 16'd0,
                       e_rdy[0], e_rdy[1], e_pend, mv[0] || mv[1]);

            if (r) begin
                mv[0] = 1'b0;
                mv[1] = 1'b0;
                mlast = 1;
            end else begin
                if (g >= 0) begin
                    mv[g] = 1'b0;
                    mlast = g;
                end
                for (int k = 0; k < 2; k++) begin
                    if (pv[k] && e_rdy[k]) begin
                        if (pt[k] != 0) begin
                            mv[k] = 1'b1;
                            mt[k] = pt[k];
                            md[k] = pd[k];
                            ms[k] = c * 2 + k;
                        end
                        pv[k] = 1'b0;
                    end
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_wr_arb.md
REGFILE_WR_ARB -- requirements
Module: regfile_wr_arb

Interface
REQ-001 The block SHALL have parameter p_WORD_LEN, default 16, data word width.
REQ-002 The block SHALL have parameter p_REG_ADDR_LEN, default 3, register address width.
REQ-003 The block SHALL have parameter p_REG_FILE_SIZE, default 8, number of registers, r0 included.
REQ-004 The block SHALL have one clock and a synchronous active-high reset: clk input 1, rising-edge clock; rst input 1, synchronous active-high reset.
REQ-005 The requester 0 (core writeback) port SHALL be: req0_valid input 1; req0_ready output 1; req0_tgt input p_REG_ADDR_LEN; req0_data input p_WORD_LEN.
REQ-006 The requester 1 (debug/host) port SHALL be: req1_valid input 1; req1_ready output 1; req1_tgt input p_REG_ADDR_LEN; req1_data input p_WORD_LEN.
REQ-007 The register file write port SHALL be: wr_en output 1, write enable; wr_tgt output p_REG_ADDR_LEN, write address; wr_data output p_WORD_LEN, write data.
REQ-008 The hazard outputs SHALL be: pend_mask output p_REG_FILE_SIZE, bit n=1 when a buffered write to rn is pending; busy output 1, at least one buffer occupied.

Function
REQ-009 The block SHALL hold one buffer per requester: valid bit, tgt, data, and one age bit marking the older of the two entries.
REQ-010 Acceptance SHALL occur on a rising clk edge with reqN_valid=1 and reqN_ready=1, loading buffer N.
REQ-011 reqN_ready SHALL be 1 when buffer N is empty or is being drained in the current cycle (same-cycle refill allowed).
REQ-012 A request with tgt=0 SHALL be accepted, SHALL never be loaded into the buffer, and SHALL cause no write.
REQ-013 Each cycle at most one occupied buffer SHALL be granted; wr_en, wr_tgt and wr_data SHALL be driven combinationally from the granted buffer, which empties on that edge.
REQ-014 Write latency SHALL be exactly 1 cycle from acceptance when uncontended: accepted at edge k, wr_en=1 during cycle k+1.
REQ-015 When both buffers are occupied with equal tgt, the older entry SHALL be granted first (write order preserved per register).
REQ-016 When both buffers are occupied with different tgt, grant SHALL be round-robin: grant the requester not granted last; last-grant pointer updates only on a grant.
REQ-017 When both requesters are accepted on the same edge into empty buffers, entry 0 SHALL be marked older.
REQ-018 When a buffer is refilled on the edge its entry drains while the other buffer stays occupied, the refilled entry SHALL become the younger.
REQ-019 When no buffer is occupied, wr_en SHALL be 0 and wr_tgt and wr_data SHALL be 0.
REQ-020 pend_mask SHALL be the OR of one-hot(tgt) over occupied buffers and SHALL be registered-state-derived only; bit 0 SHALL always be 0.
REQ-021 busy SHALL equal the OR of the buffer valid bits.

Reset
REQ-022 While rst=1 on an edge, both buffers SHALL be emptied, the age bit and last-grant pointer set to requester 1 so requester 0 is granted first, and requests ignored.
REQ-023 During the cycle after reset, wr_en=0, pend_mask=0, busy=0, and req0_ready=req1_ready=1 SHALL hold.
REQ-024 Reset asserted mid-operation SHALL discard buffered writes without issuing them.

Structure
REQ-025 Default widths and the requester index constants (REQ_CORE=0, REQ_DBG=1) SHALL live in a shared header included by the core and this block.
REQ-026 The per-requester buffer SHALL be one sub-module, wr_slot, instantiated twice; arbitration and age logic SHALL stay in the top.

Verification
REQ-027 The bench SHALL cover single write: req0 tgt=3 data=0x1234 at edge k -> wr_en=1, wr_tgt=3, wr_data=0x1234 in cycle k+1, pend_mask=0x08 in cycle k+1.
REQ-028 The bench SHALL cover simultaneous writes to different registers: req0 tgt=2 and req1 tgt=5 on the same edge after reset -> r2 written first, r5 next cycle, then round-robin alternation under continuous traffic.
REQ-029 The bench SHALL cover simultaneous writes to the same register: req1 tgt=4 data=0xAAAA accepted one edge before req0 tgt=4 data=0x5555 while blocked -> 0xAAAA written before 0x5555.
REQ-030 The bench SHALL cover the r0 drop: req1 tgt=0 data=0xFFFF -> accepted, wr_en stays 0, pend_mask bit 0 stays 0, busy stays 0.
REQ-031 The bench SHALL cover back-to-back traffic: req0 valid every cycle, tgts 1..7 -> ready stays 1 and one write per cycle in order, with no gaps.
REQ-032 The bench SHALL cover reset mid-operation: both buffers full, rst=1 for one edge -> no writes issued, busy=0 and pend_mask=0 the next cycle.
